// File: rtl/mem_pkg.sv
// Shared memory-side definitions for the load/store units.
package mem_pkg;

    // Store types share the funct3 encoding of the load types (LB/LH/LW).
    localparam logic [2:0] ST_SB = 3'b000;
    localparam logic [2:0] ST_SH = 3'b001;
    localparam logic [2:0] ST_SW = 3'b010;

    localparam int WORD_BYTES = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BEAT_LO = 2'd1,
        BEAT_HI = 2'd2
    } st_state_e;

endpackage

// File: rtl/store_lane_align.sv
// Combinational lane placement: turns (byte offset, data, type) into a
// 64-bit two-word data image and an 8-bit byte mask spanning both words.
module store_lane_align
    import mem_pkg::*;
(
    input  logic [1:0]  addr_lo,
    input  logic [31:0] data,
    input  logic [2:0]  st_type,
    output logic [63:0] d,
    output logic [7:0]  m,
    output logic        split,
    output logic        valid_type
);

    logic [3:0]  bmask;
    logic [63:0] dz;

    // Pick size-dependent mask and zero-extended data, then shift into lanes.
    always_comb begin
        bmask      = 4'b0000;
        dz         = 64'd0;
        valid_type = 1'b1;
        case (st_type)
            ST_SB: begin
                bmask = 4'b0001;
                dz    = {56'd0, data[7:0]};
            end
            ST_SH: begin
                bmask = 4'b0011;
                dz    = {48'd0, data[15:0]};
            end
            ST_SW: begin
                bmask = 4'b1111;
                dz    = {32'd0, data};
            end
            default: valid_type = 1'b0;
        endcase
        m     = {4'b0000, bmask} << addr_lo;
        d     = dz << {addr_lo, 3'b000};
        split = |m[7:4];
    end

endmodule

// File: rtl/store_unit.sv
// Store unit: accepts SB/SH/SW with any alignment and drives a registered
// word-wide write port with byte strobes, splitting word-crossing stores
// into two consecutive beats.
module store_unit
    import mem_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int MEM_SIZE   = 512
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    st_valid,
    output logic                    st_ready,
    input  logic [ADDR_WIDTH-1:0]   st_addr,
    input  logic [DATA_WIDTH-1:0]   st_data,
    input  logic [2:0]              st_type,
    output logic                    mem_we,
    output logic [ADDR_WIDTH-3:0]   mem_waddr,
    output logic [DATA_WIDTH-1:0]   mem_wdata,
    output logic [WORD_BYTES-1:0]   mem_wstrb,
    output logic                    st_done,
    output logic                    st_err
);

    // Word index limit widened by one bit so w+1 never wraps to 0.
    localparam logic [ADDR_WIDTH-2:0] MEM_LIMIT = (ADDR_WIDTH-1)'(MEM_SIZE);

    st_state_e state, state_nx;

    logic [63:0] al_d;
    logic [7:0]  al_m;
    logic        al_split;
    logic        al_valid;

    logic [ADDR_WIDTH-2:0] w_ext;
    logic [ADDR_WIDTH-2:0] w_hi;
    logic                  lo_oor;
    logic                  hi_oor;
    logic                  accept;

    // Pending high beat, captured at accept.
    logic                  split_q;
    logic [ADDR_WIDTH-3:0] hi_waddr_q;
    logic [31:0]           hi_wdata_q;
    logic [3:0]            hi_wstrb_q;
    logic                  hi_oor_q;
    logic                  lo_oor_q;

    store_lane_align u_align (
        .addr_lo    (st_addr[1:0]),
        .data       (st_data),
        .st_type    (st_type),
        .d          (al_d),
        .m          (al_m),
        .split      (al_split),
        .valid_type (al_valid)
    );

    assign w_ext  = {1'b0, st_addr[ADDR_WIDTH-1:2]};
    assign w_hi   = w_ext + 1'b1;
    assign lo_oor = (w_ext >= MEM_LIMIT);
    assign hi_oor = (w_hi  >= MEM_LIMIT);
    assign accept = st_valid && st_ready;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // Next state and ready; ready depends only on state, split flag and reset.
    always_comb begin
        state_nx = state;
        st_ready = 1'b0;
        case (state)
            IDLE: begin
                st_ready = 1'b1;
                if (accept) state_nx = BEAT_LO;
            end
            BEAT_LO: begin
                if (split_q) begin
                    state_nx = BEAT_HI;
                end else begin
                    st_ready = 1'b1;
                    state_nx = accept ? BEAT_LO : IDLE;
                end
            end
            BEAT_HI: begin
                st_ready = 1'b1;
                state_nx = accept ? BEAT_LO : IDLE;
            end
            default: state_nx = IDLE;
        endcase
        if (rst) st_ready = 1'b0;
    end

    // Write port: load beat 1 on accept, the high beat after a split low
    // beat, otherwise drop the write strobes and completion pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_we     <= 1'b0;
            mem_waddr  <= '0;
            mem_wdata  <= '0;
            mem_wstrb  <= '0;
            st_done    <= 1'b0;
            st_err     <= 1'b0;
            split_q    <= 1'b0;
            hi_waddr_q <= '0;
            hi_wdata_q <= '0;
            hi_wstrb_q <= '0;
            hi_oor_q   <= 1'b0;
            lo_oor_q   <= 1'b0;
        end else if (accept) begin
            mem_we     <= al_valid && !lo_oor;
            mem_waddr  <= st_addr[ADDR_WIDTH-1:2];
            mem_wdata  <= al_d[31:0];
            mem_wstrb  <= (al_valid && !lo_oor) ? al_m[3:0] : 4'b0000;
            st_done    <= !al_split;
            st_err     <= !al_split && (!al_valid || lo_oor);
            split_q    <= al_split;
            hi_waddr_q <= w_hi[ADDR_WIDTH-3:0];
            hi_wdata_q <= al_d[63:32];
            hi_wstrb_q <= al_m[7:4];
            hi_oor_q   <= hi_oor;
            lo_oor_q   <= lo_oor;
        end else if (state == BEAT_LO && split_q) begin
            mem_we     <= !hi_oor_q;
            mem_waddr  <= hi_waddr_q;
            mem_wdata  <= hi_wdata_q;
            mem_wstrb  <= hi_oor_q ? 4'b0000 : hi_wstrb_q;
            st_done    <= 1'b1;
            st_err     <= lo_oor_q || hi_oor_q;
            split_q    <= 1'b0;
        end else begin
            mem_we     <= 1'b0;
            mem_wstrb  <= 4'b0000;
            st_done    <= 1'b0;
            st_err     <= 1'b0;
            split_q    <= 1'b0;
        end
    end

endmodule
